free_list_manager: RTL and testbench

FREE_LIST_MANAGER -- requirements
Module: free_list_manager

---
 rtl/free_list_manager.sv | 119 +++++++++++
 tb/tb_free_list_manager.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/free_list_manager.sv
// Free list of physical register tags for a superscalar rename stage.
//
// Free tags live in a circular buffer of Depth = PRF_SIZE - ARCH_REGS entries.
// Three pointers, each carrying an extra wrap bit, walk the buffer:
//   head  - next tag to hand to dispatch
//   tail  - next slot to receive a tag released at retire
//   rhead - where head would be if only retired instructions had allocated;
//           recovery snaps head back to it, returning squashed tags at once.
// Depth must be a power of two so the low pointer bits index the buffer directly.
//
// Ports:
//   clock_i        clock, all state on the rising edge
//   reset_i        synchronous active-high reset
//   alloc_req_i    per dispatch slot, wants one destination tag
//   alloc_grant_o  per slot, tag granted this cycle (all-or-nothing)
//   alloc_tag_o    per slot, tag offered to that slot
//   stall_o        more tags requested than are free
//   ret_valid_i    per retire slot, retiring instruction releases a tag
//   ret_tag_old_i  per retire slot, superseded tag being released
//   recover_i      squash all non-retired allocations
//   free_count_o   registered number of free tags
module free_list_manager #(
  parameter int unsigned N_WAY     = 2,
  parameter int unsigned PRF_SIZE  = 64,
  parameter int unsigned ARCH_REGS = 32,
  parameter int unsigned TAG_BITS  = 6
) (
  input  logic                             clock_i,
  input  logic                             reset_i,
  input  logic [N_WAY-1:0]                 alloc_req_i,
  output logic [N_WAY-1:0]                 alloc_grant_o,
  output logic [N_WAY-1:0][TAG_BITS-1:0]   alloc_tag_o,
  output logic                             stall_o,
  input  logic [N_WAY-1:0]                 ret_valid_i,
  input  logic [N_WAY-1:0][TAG_BITS-1:0]   ret_tag_old_i,
  input  logic                             recover_i,
  output logic [TAG_BITS-1:0]              free_count_o
);

  localparam int unsigned Depth   = PRF_SIZE - ARCH_REGS;
  localparam int unsigned IdxBits = $clog2(Depth);
  localparam int unsigned PtrBits = IdxBits + 1;

  logic [TAG_BITS-1:0] mem_q [Depth];

  logic [PtrBits-1:0]  head_q, head_d;
  logic [PtrBits-1:0]  tail_q, tail_d;
  logic [PtrBits-1:0]  rhead_q, rhead_d;
  logic [TAG_BITS-1:0] free_count_q, free_count_d;

  logic [PtrBits-1:0]              req_cnt, ret_cnt;
  logic [N_WAY-1:0][IdxBits-1:0]   req_off, ret_off;
  logic [N_WAY-1:0][IdxBits-1:0]   rd_idx, wr_idx;
  logic                            grant_en;

  always_comb begin
    req_cnt = '0;
    ret_cnt = '0;
    req_off = '0;
    ret_off = '0;
    rd_idx  = '0;
    wr_idx  = '0;
    // Prefix counts compact the active slots onto consecutive buffer entries.
    for (int unsigned n = 0; n < N_WAY; n++) begin
      req_off[n] = req_cnt[IdxBits-1:0];
      ret_off[n] = ret_cnt[IdxBits-1:0];
      req_cnt    = req_cnt + PtrBits'(alloc_req_i[n]);
      ret_cnt    = ret_cnt + PtrBits'(ret_valid_i[n]);
    end

    // Compared against the registered count, so same-cycle frees never bypass.
    stall_o  = 32'(req_cnt) > 32'(free_count_q);
    grant_en = !stall_o && !recover_i && !reset_i;
    alloc_grant_o = grant_en ? alloc_req_i : '0;

    for (int unsigned n = 0; n < N_WAY; n++) begin
      rd_idx[n]      = head_q[IdxBits-1:0] + req_off[n];
      wr_idx[n]      = tail_q[IdxBits-1:0] + ret_off[n];
      alloc_tag_o[n] = mem_q[rd_idx[n]];
    end

    rhead_d = rhead_q + ret_cnt;
    tail_d  = tail_q + ret_cnt;
    if (recover_i) begin
      head_d = rhead_d;
    end else if (grant_en) begin
      head_d = head_q + req_cnt;
    end else begin
      head_d = head_q;
    end
    free_count_d = TAG_BITS'(tail_d - head_d);
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      head_q       <= '0;
      rhead_q      <= '0;
      tail_q       <= PtrBits'(Depth - 1);
      free_count_q <= TAG_BITS'(Depth - 1);
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= (i < Depth - 1) ? TAG_BITS'(ARCH_REGS + 1 + i) : '0;
      end
    end else begin
      head_q       <= head_d;
      rhead_q      <= rhead_d;
      tail_q       <= tail_d;
      free_count_q <= free_count_d;
      // Retire frees are written even during recovery.
      for (int unsigned n = 0; n < N_WAY; n++) begin
        if (ret_valid_i[n]) begin
          mem_q[wr_idx[n]] <= ret_tag_old_i[n];
        end
      end
    end
  end

  assign free_count_o = free_count_q;

endmodule

// File: tb/tb_free_list_manager.sv
module tb_free_list_manager;

  logic            clk = 1'b0;
  logic            reset;
  logic [1:0]      alloc_req;
  logic [1:0]      alloc_grant;
  logic [1:0][5:0] alloc_tag;
  logic            stall;
  logic [1:0]      ret_valid;
  logic [1:0][5:0] ret_tag_old;
  logic            recover;
  logic [5:0]      free_count;

  int checks   = 0;
  int failures = 0;

  localparam logic [4:0] MG = 5'b00001, MS = 5'b00010, MT0 = 5'b00100, MT1 = 5'b01000,
                         MF = 5'b10000;

  typedef struct {
    string      name;
    logic [4:0] mask;
    logic [1:0] grant;
    logic       st;
    logic [5:0] t0;
    logic [5:0] t1;
    logic [5:0] fc;
  } exp_t;

  exp_t sb_q[$];

  free_list_manager #(
    .N_WAY(2), .PRF_SIZE(64), .ARCH_REGS(32), .TAG_BITS(6)
  ) dut (
    .clock_i      (clk),
    .reset_i      (reset),
    .alloc_req_i  (alloc_req),
    .alloc_grant_o(alloc_grant),
    .alloc_tag_o  (alloc_tag),
    .stall_o      (stall),
    .ret_valid_i  (ret_valid),
    .ret_tag_old_i(ret_tag_old),
    .recover_i    (recover),
    .free_count_o (free_count)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  function automatic void chk(string nm, logic [7:0] act, logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endfunction

  // Monitor: each cycle's expectation is checked mid-cycle, after inputs settle.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      if (e.mask[0]) chk({e.name, "/grant"}, {6'd0, alloc_grant}, {6'd0, e.grant});
      if (e.mask[1]) chk({e.name, "/stall"}, {7'd0, stall}, {7'd0, e.st});
      if (e.mask[2]) chk({e.name, "/tag0"}, {2'd0, alloc_tag[0]}, {2'd0, e.t0});
      if (e.mask[3]) chk({e.name, "/tag1"}, {2'd0, alloc_tag[1]}, {2'd0, e.t1});
      if (e.mask[4]) chk({e.name, "/free_count"}, {2'd0, free_count}, {2'd0, e.fc});
    end
  end

  task automatic step(input string nm, input logic rst, input logic [1:0] req,
                      input logic [1:0] rv, input logic [5:0] r0, input logic [5:0] r1,
                      input logic rec, input logic [4:0] mask, input logic [1:0] g,
                      input logic st, input logic [5:0] t0, input logic [5:0] t1,
                      input logic [5:0] fc);
    exp_t e;
    reset          = rst;
    alloc_req      = req;
    ret_valid      = rv;
    ret_tag_old[0] = r0;
    ret_tag_old[1] = r1;
    recover        = rec;
    e.name = nm; e.mask = mask; e.grant = g; e.st = st; e.t0 = t0; e.t1 = t1; e.fc = fc;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step("rst_a", 1'b1, 2'b11, 2'b00, 6'd0, 6'd0, 1'b0, MG, 2'b00, 1'b0, 6'd0, 6'd0, 6'd0);
    step("rst_b", 1'b1, 2'b11, 2'b00, 6'd0, 6'd0, 1'b0, MG | MF, 2'b00, 1'b0, 6'd0, 6'd0,
         6'd31);
  endtask

  // Reference model for the churn phase.
  logic [5:0] fq[$];
  logic [5:0] rob[$];
  logic [5:0] amap[32];

  task automatic churn(input int cycles);
    fq.delete();
    rob.delete();
    for (int t = 33; t < 64; t++) fq.push_back(6'(t));
    for (int r = 0; r < 32; r++) amap[r] = 6'(r + 1);
    for (int c = 0; c < cycles; c++) begin
      logic [1:0]      req, rv, g;
      logic [1:0][5:0] te, rt;
      logic [4:0]      mask;
      logic            st;
      int              k, j;
      req = 2'($urandom_range(0, 3));
      rv  = 2'($urandom_range(0, 3));
      if ($countones(rv) > rob.size()) rv = 2'b00;
      st   = $countones(req) > fq.size();
      g    = st ? 2'b00 : req;
      te   = '0;
      rt   = '0;
      mask = MG | MS | MF;
      k = 0;
      for (int n = 0; n < 2; n++) begin
        if (g[n]) begin
          te[n] = fq[k];
          k++;
          mask = mask | (n == 0 ? MT0 : MT1);
        end
      end
      j = 0;
      for (int n = 0; n < 2; n++) begin
        if (rv[n]) begin
          rt[n] = rob[j];
          j++;
        end
      end
      step("churn", 1'b0, req, rv, rt[0], rt[1], 1'b0, mask, g, st, te[0], te[1],
           6'(fq.size()));
      for (int n = 0; n < k; n++) begin
        int r;
        r = $urandom_range(0, 31);
        void'(fq.pop_front());
        rob.push_back(amap[r]);
        amap[r] = te[n];
      end
      for (int n = 0; n < j; n++) fq.push_back(rob.pop_front());
    end
  endtask

  initial begin
    reset = 1'b1; alloc_req = '0; ret_valid = '0; ret_tag_old = '0; recover = 1'b0;
    @(posedge clk);
    #1;

    // Pair allocation straight out of reset.
    do_reset();
    step("pair", 1'b0, 2'b11, 2'b00, 6'd0, 6'd0, 1'b0, MG | MS | MT0 | MT1 | MF, 2'b11, 1'b0,
         6'd33, 6'd34, 6'd31);
    step("pair_fc", 1'b0, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0, MG | MF, 2'b00, 1'b0, 6'd0, 6'd0,
         6'd29);

    // Only slot 1 requests: it takes the head entry.
    do_reset();
    step("slot1", 1'b0, 2'b10, 2'b00, 6'd0, 6'd0, 1'b0, MG | MS | MT1 | MF, 2'b10, 1'b0,
         6'd0, 6'd33, 6'd31);
    step("slot1_fc", 1'b0, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0, MF, 2'b00, 1'b0, 6'd0, 6'd0, 6'd30);

    // Drain to one free tag, stall on a pair, then grant a single.
    do_reset();
    for (int i = 0; i < 15; i++) begin
      step("drain", 1'b0, 2'b11, 2'b00, 6'd0, 6'd0, 1'b0, MG | MT0 | MT1 | MF, 2'b11, 1'b0,
           6'(33 + 2 * i), 6'(34 + 2 * i), 6'(31 - 2 * i));
    end
    step("stall_pair", 1'b0, 2'b11, 2'b00, 6'd0, 6'd0, 1'b0, MG | MS | MF, 2'b00, 1'b1,
         6'd0, 6'd0, 6'd1);
    step("last_one", 1'b0, 2'b01, 2'b00, 6'd0, 6'd0, 1'b0, MG | MS | MT0 | MF, 2'b01, 1'b0,
         6'd63, 6'd0, 6'd1);

    // Empty list: same-cycle frees are not bypassed, usable next cycle.
    step("empty_stall", 1'b0, 2'b01, 2'b11, 6'd5, 6'd6, 1'b0, MG | MS | MF, 2'b00, 1'b1,
         6'd0, 6'd0, 6'd0);
    step("freed_grant", 1'b0, 2'b01, 2'b00, 6'd0, 6'd0, 1'b0, MG | MS | MT0 | MF, 2'b01, 1'b0,
         6'd5, 6'd0, 6'd2);
    step("freed_fc", 1'b0, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0, MF, 2'b00, 1'b0, 6'd0, 6'd0, 6'd1);

    // Recovery with a same-cycle retire of two instructions.
    do_reset();
    step("rec_a1", 1'b0, 2'b11, 2'b00, 6'd0, 6'd0, 1'b0, MG | MT0 | MT1, 2'b11, 1'b0,
         6'd33, 6'd34, 6'd0);
    step("rec_a2", 1'b0, 2'b11, 2'b00, 6'd0, 6'd0, 1'b0, MG | MT0 | MT1 | MF, 2'b11, 1'b0,
         6'd35, 6'd36, 6'd29);
    step("rec", 1'b0, 2'b11, 2'b11, 6'd5, 6'd6, 1'b1, MG | MS | MF, 2'b00, 1'b0,
         6'd0, 6'd0, 6'd27);
    // head = rhead = 2, tail = 33 after the edge.
    step("rec_post", 1'b0, 2'b01, 2'b00, 6'd0, 6'd0, 1'b0, MG | MT0 | MF, 2'b01, 1'b0,
         6'd35, 6'd0, 6'd31);
    step("rec_next", 1'b0, 2'b01, 2'b00, 6'd0, 6'd0, 1'b0, MG | MT0 | MF, 2'b01, 1'b0,
         6'd36, 6'd0, 6'd30);
    for (int i = 0; i < 13; i++) begin
      step("rec_walk", 1'b0, 2'b11, 2'b00, 6'd0, 6'd0, 1'b0, MG | MT0 | MT1 | MF, 2'b11, 1'b0,
           6'(37 + 2 * i), 6'(38 + 2 * i), 6'(29 - 2 * i));
    end
    step("wrap_pair", 1'b0, 2'b11, 2'b00, 6'd0, 6'd0, 1'b0, MG | MT0 | MT1 | MF, 2'b11, 1'b0,
         6'd63, 6'd5, 6'd3);
    step("wrap_six", 1'b0, 2'b01, 2'b00, 6'd0, 6'd0, 1'b0, MG | MT0 | MF, 2'b01, 1'b0,
         6'd6, 6'd0, 6'd1);
    step("wrap_fc", 1'b0, 2'b01, 2'b00, 6'd0, 6'd0, 1'b0, MG | MS | MF, 2'b00, 1'b1,
         6'd0, 6'd0, 6'd0);

    // Random alloc/retire churn against the reference model.
    do_reset();
    churn(160);

    step("idle", 1'b0, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 5'b00000, 2'b00, 1'b0, 6'd0, 6'd0, 6'd0);
    repeat (2) @(negedge clk);
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
